// File: rtl/rot_pkg.sv
// Shared types and constants for the sequential rotator: FSM state encoding and default width.
package rot_pkg;

   localparam int ROT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } rot_state_t;

endpackage

// File: rtl/rotate_right_seq.sv
// Sequential rotator: one bit position per cycle, valid/ready on both channels.
// Define ROT_DIR_SEL_EN to add in_dir (0 = right, 1 = left) sampled on accept.
module rotate_right_seq
   import rot_pkg::*;
#(
   parameter int WIDTH = ROT_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [$clog2(WIDTH)-1:0]   in_shift,
`ifdef ROT_DIR_SEL_EN
   input  logic                       in_dir,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       busy
);

   localparam int SHIFT_W = $clog2(WIDTH);

   rot_state_t          state_reg;
   logic [WIDTH-1:0]    data_reg;
   logic [SHIFT_W-1:0]  count_reg;
   logic [WIDTH-1:0]    step_data;

`ifdef ROT_DIR_SEL_EN
   logic                dir_reg;

   always_comb begin
      step_data = {data_reg[0], data_reg[WIDTH-1:1]};
      if (dir_reg) begin
         step_data = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
      end
   end
`else
   always_comb begin
      step_data = {data_reg[0], data_reg[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         count_reg <= '0;
`ifdef ROT_DIR_SEL_EN
         dir_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg  <= in_data;
                  count_reg <= in_shift;
`ifdef ROT_DIR_SEL_EN
                  dir_reg   <= in_dir;
`endif
                  state_reg <= (in_shift == '0) ? DONE : ROTATE;
               end
            end
            ROTATE: begin
               // count holds the steps still to do, including this one
               data_reg  <= step_data;
               count_reg <= count_reg - SHIFT_W'(1);
               if (count_reg == SHIFT_W'(1)) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_data  = data_reg;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: vector table, hand-written corner sequences,
// exhaustive sweep and random transactions against a rotate reference model.
module tb_rotate_right_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_shift;
   logic       in_dir;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   rotate_right_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
`ifdef ROT_DIR_SEL_EN
      .in_dir    (in_dir),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [7:0] data;
      logic [2:0] shift;
      int         hold;
      logic [7:0] exp;
   } vec_t;

   // Rotation as whole-word arithmetic on a doubled copy of the operand.
   function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s, input logic dir);
      logic [15:0] w;
      w = {d, d};
      if (dir) begin
         w = w << s;
         return w[15:8];
      end
      w = w >> s;
      return w[7:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic run_txn(input logic [7:0] d, input logic [2:0] s, input logic dir,
                          input int hold, input logic [7:0] exp, input string tag);
      int   lat;
      logic busy_ok;
      logic hold_ok;
      check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_data   = d;
      in_shift  = s;
      in_dir    = dir;
      out_ready = (hold == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      busy_ok  = 1'b1;
      while (!out_valid && lat < 40) begin
         if (!busy || in_ready) busy_ok = 1'b0;
         in_data  = 8'($urandom);
         in_shift = 3'($urandom);
         @(negedge clk);
         lat++;
      end
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " latency"}, lat, 32'(int'(s) + 1));
      check({tag, " busy during op"}, {31'd0, busy_ok & busy}, 32'd1);
      check({tag, " out_data"}, {24'd0, out_data}, {24'd0, exp});
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_shift = 3'($urandom);
         @(negedge clk);
         if (!out_valid || out_data !== exp || in_ready) hold_ok = 1'b0;
      end
      if (hold > 0) check({tag, " hold stable"}, {31'd0, hold_ok}, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " idle after deliver"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
      check({tag, " out_data retained"}, {24'd0, out_data}, {24'd0, exp});
      $display("txn %s: data=%02h shift=%0d dir=%0d -> %02h latency=%0d", tag, d, s, dir, out_data, lat);
   endtask

   initial begin
      vec_t vecs[7];
      logic [7:0] d;
      logic [2:0] s;
      logic       dir;
      int         hold;
      logic       seen;

      vecs[0] = '{8'b10110011, 3'd3, 0, 8'b01110110};
      vecs[1] = '{8'b10011101, 3'd3, 0, 8'b10110011};
      vecs[2] = '{8'hA5,       3'd0, 0, 8'hA5};
      vecs[3] = '{8'h01,       3'd1, 0, 8'h80};
      vecs[4] = '{8'h80,       3'd7, 1, 8'h01};
      vecs[5] = '{8'hC3,       3'd4, 5, 8'h3C};
      vecs[6] = '{8'h12,       3'd2, 2, 8'h84};

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_shift = 3'd0;
      in_dir = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset state", {20'd0, out_valid, in_ready, busy, 1'b0, out_data}, {20'd0, 4'b0100, 8'h00});

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].data, vecs[i].shift, 1'b0, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Abort a shift-7 rotation on its second cycle.
      in_valid = 1'b1; in_data = 8'h5B; in_shift = 3'd7; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort state", {20'd0, out_valid, in_ready, busy, 1'b0, out_data}, {20'd0, 4'b0100, 8'h00});
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort no result", {31'd0, seen}, 32'd0);
      out_ready = 1'b0;
      $display("txn abort: shift=7 aborted by reset");
      run_txn(8'h01, 3'd1, 1'b0, 0, 8'h80, "after_abort");

      // Reset wins over a simultaneous request.
      reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_shift = 3'd0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      check("reset priority", {20'd0, out_valid, in_ready, busy, 1'b0, out_data}, {20'd0, 4'b0100, 8'h00});
      $display("txn reset_priority: request during reset ignored");

`ifdef ROT_DIR_SEL_EN
      run_txn(8'b10110011, 3'd3, 1'b1, 0, 8'b10011101, "dir_left");
`endif

      for (int dv = 0; dv < 256; dv++) begin
         for (int sv = 0; sv < 8; sv++) begin
            run_txn(8'(dv), 3'(sv), 1'b0, 0, ref_rot(8'(dv), sv, 1'b0), "sweep");
         end
      end

      for (int i = 0; i < 60; i++) begin
         d    = 8'($urandom);
         s    = 3'($urandom_range(0, 7));
         hold = int'($urandom_range(0, 3));
         dir  = 1'b0;
`ifdef ROT_DIR_SEL_EN
         dir  = 1'($urandom);
`endif
         run_txn(d, s, dir, hold, ref_rot(d, int'(s), dir), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rotate_right_seq.md
ROTATE_RIGHT_SEQ -- requirements
Module: rotate_right_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width; power of two, at least 2.
REQ-002 The block SHALL have derived localparam SHIFT_W, equal to $clog2(WIDTH): shift-amount width (3 at default).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, WIDTH) and in_shift (input, SHIFT_W): request channel.
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, WIDTH): result channel.
REQ-007 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-008 The block SHALL rotate in_data right by in_shift positions, with bits leaving bit 0 re-entering at bit WIDTH-1; this is the inverse of the team's combinational left rotator.
REQ-009 The FSM SHALL have exactly the states IDLE, ROTATE and DONE.
REQ-010 in_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-011 On accept, in_data and in_shift SHALL be registered into a data register and a count register; the next state SHALL be DONE if in_shift==0, else ROTATE.
REQ-012 In ROTATE, each cycle SHALL rotate the data register right by exactly 1 and decrement the count; when count==1, the next state SHALL be DONE.
REQ-013 Latency from the accept edge to out_valid=1 SHALL be in_shift+1 cycles (1 cycle for in_shift=0; 8 cycles for in_shift=7).
REQ-014 In DONE, out_valid SHALL be 1 and out_data SHALL equal the data register, held stable until out_ready=1.
REQ-015 On a DONE cycle with out_ready=1, the next state SHALL be IDLE; in_ready SHALL rise on the following cycle, with no accept/deliver overlap.
REQ-016 in_data and in_shift changes while not in IDLE SHALL be ignored.
REQ-017 out_data SHALL be a register output and SHALL retain the last result in IDLE; out_valid SHALL be 0 outside DONE.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE, clear the data register and count to 0, and yield out_valid=0, out_data=0, busy=0 and in_ready=1 after that edge.
REQ-019 reset asserted during ROTATE or DONE SHALL abort the operation; no result SHALL be delivered, and the next accepted request SHALL start clean.
REQ-020 reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-021 Macro ROT_DIR_SEL_EN defined: the block SHALL add port in_dir (input, 1 bit), registered on accept; 0 = rotate right, 1 = rotate left by one per ROTATE cycle; latency SHALL be unchanged.
REQ-022 Macro ROT_DIR_SEL_EN undefined: port in_dir SHALL not exist, and the block SHALL rotate right only.

Structure
REQ-023 Package rot_pkg SHALL hold the state enum typedef (IDLE, ROTATE, DONE) and the default width constant ROT_WIDTH=8.
REQ-024 The block SHALL be a single module; no sub-module is required, and the one-bit rotate step SHALL be an inline expression.

Verification
REQ-025 The bench SHALL cover: reset, then in_data=8'b10110011, in_shift=3, out_ready=1 -> out_valid rises on cycle 4 after accept, out_data=8'b01110110, and busy is high throughout.
REQ-026 The bench SHALL cover round-trip: in_data=8'b10011101, in_shift=3 -> out_data=8'b10110011; all 256 data values x 8 shifts match a rotate-right reference model.
REQ-027 The bench SHALL cover in_shift=0 with in_data=8'hA5 -> out_valid exactly 1 cycle after accept, out_data=8'hA5.
REQ-028 The bench SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data are stable; in_ready=0 and new in_valid is ignored; the handshake then completes and IDLE follows.
REQ-029 The bench SHALL cover reset pulsed on cycle 2 of an in_shift=7 rotation -> out_valid never rises, out_data=0, in_ready=1; a following in_data=8'h01, in_shift=1 request gives 8'h80.
REQ-030 The bench SHALL cover, with ROT_DIR_SEL_EN defined, in_dir=1, in_data=8'b10110011, in_shift=3 -> out_data=8'b10011101.
